// File: rtl/bram_pkg.sv
// Shared types and helpers for the boot-loadable BRAM block.
// - bram_state_e : port ownership, LOAD (streamer) or RUN (AXI BRAM controller)
// - idx_width()  : word-index width for a byte address of aw bits and dw-bit words
package bram_pkg;

  typedef enum logic {LOAD, RUN} bram_state_e;

  function automatic int idx_width(input int aw, input int dw);
    return aw - $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/bram_sp_array.sv
// Byte-lane storage array with one write port and a registered, read-first output.
// Ports:
//   clk    : clock
//   rd_clr : clears the output register (array contents untouched)
//   rd_en  : capture the addressed word into the output register
//   we     : per-byte-lane write enables
//   addr   : word index shared by read and write
//   wdata  : write data
//   rdata  : registered read data, holds until the next read or clear
module bram_sp_array
  import bram_pkg::*;
#(
  parameter int NB = 16,
  parameter int IW = 12
) (
  input  logic              clk,
  input  logic              rd_clr,
  input  logic              rd_en,
  input  logic [NB-1:0]     we,
  input  logic [IW-1:0]     addr,
  input  logic [NB*8-1:0]   wdata,
  output logic [NB*8-1:0]   rdata
);

  // One narrow array per lane keeps byte enables trivially mappable onto
  // block RAM byte-write columns.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] mem [2**IW];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (we[gi]) mem[addr] <= wdata[gi*8 +: 8];
    end

    // Non-blocking read of mem gives read-first behaviour on a same-cycle write.
    always_ff @(posedge clk) begin
      if (rd_clr)     rd_q <= '0;
      else if (rd_en) rd_q <= mem[addr];
    end

    assign rdata[gi*8 +: 8] = rd_q;
  end

endmodule

// File: rtl/bram_boot_mem.sv
// Memory behind the AXI BRAM controller native port, with a streaming boot
// loader that owns the array after reset until the last image beat arrives.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   ram_rst                  : clears read output registers only
//   ram_en/we/addr/wrdata    : controller native port (byte address)
//   ram_rddata               : read data, RD_LATENCY cycles after ram_en
//   ld_valid/ld_ready        : loader handshake
//   ld_addr/ld_data/ld_last  : loader beat word index, data, final-beat flag
//   boot_done                : controller owns the memory
//   ld_err                   : sticky, a beat addressed beyond the array was seen
//   ld_count                 : beats accepted (saturating)
module bram_boot_mem
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int RD_LATENCY = 1,
  parameter bit BOOT_LOAD  = 1'b1,
  localparam int NB  = DATA_WIDTH / 8,
  localparam int IW  = idx_width(ADDR_WIDTH, DATA_WIDTH),
  localparam int LBW = $clog2(NB)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ram_rst,
  input  logic                  ram_en,
  input  logic [NB-1:0]         ram_we,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_wrdata,
  output logic [DATA_WIDTH-1:0] ram_rddata,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  // One bit wider than the index so out-of-range beats are visible
  // instead of silently aliasing onto low words.
  input  logic [IW:0]           ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  boot_done,
  output logic                  ld_err,
  output logic [IW:0]           ld_count
);

  bram_state_e     state_q;
  logic            ld_ready_q, boot_done_q, ld_err_q;
  logic [IW:0]     ld_count_q, ld_count_d;
  logic            ld_accept, ld_in_range;

  logic [NB-1:0]         arr_we;
  logic [IW-1:0]         arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata, arr_rdata;
  logic                  arr_rd_en;

  // ld_ready_q is only ever high in LOAD, so it doubles as the state gate.
  assign ld_accept   = ld_valid & ld_ready_q;
  assign ld_in_range = ~ld_addr[IW];
  assign ld_count_d  = (&ld_count_q) ? ld_count_q : ld_count_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT_LOAD ? LOAD : RUN;
      ld_ready_q  <= BOOT_LOAD;
      boot_done_q <= !BOOT_LOAD;
      ld_err_q    <= 1'b0;
      ld_count_q  <= '0;
    end else if (state_q == LOAD && ld_accept) begin
      ld_count_q <= ld_count_d;
      if (!ld_in_range) ld_err_q <= 1'b1;
      if (ld_last) begin
        state_q     <= RUN;
        ld_ready_q  <= 1'b0;
        boot_done_q <= 1'b1;
      end
    end
  end

  // Port mux: loader owns the array in LOAD, the controller in RUN.
  always_comb begin
    arr_we    = '0;
    arr_addr  = ram_addr[ADDR_WIDTH-1:LBW];
    arr_wdata = ram_wrdata;
    arr_rd_en = 1'b0;
    if (state_q == LOAD) begin
      arr_addr  = ld_addr[IW-1:0];
      arr_wdata = ld_data;
      if (ld_accept && ld_in_range && !rst) arr_we = '1;
    end else if (!rst) begin
      arr_rd_en = ram_en;
      if (ram_en) arr_we = ram_we;
    end
  end

  bram_sp_array #(.NB(NB), .IW(IW)) u_array (
    .clk    (clk),
    .rd_clr (rst | ram_rst),
    .rd_en  (arr_rd_en),
    .we     (arr_we),
    .addr   (arr_addr),
    .wdata  (arr_wdata),
    .rdata  (arr_rdata)
  );

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  rd_vld_q;
    logic [DATA_WIDTH-1:0] rd2_q;
    // rd_vld_q marks a read landing in the array register this cycle; clearing
    // it on ram_rst drops any read still in flight.
    always_ff @(posedge clk) begin
      if (rst || ram_rst) begin
        rd_vld_q <= 1'b0;
        rd2_q    <= '0;
      end else begin
        rd_vld_q <= arr_rd_en;
        if (rd_vld_q) rd2_q <= arr_rdata;
      end
    end
    assign ram_rddata = rd2_q;
  end else begin : g_lat1
    assign ram_rddata = arr_rdata;
  end

  assign ld_ready  = ld_ready_q;
  assign boot_done = boot_done_q;
  assign ld_err    = ld_err_q;
  assign ld_count  = ld_count_q;

endmodule
